// File: rtl/ring_counter_pkg.sv
// Shared encodings for the ring/Johnson pattern generator.
package ring_counter_pkg;

  // Pattern select as seen on the mode input and held in mode_q.
  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_e;

  // Shift direction as seen on the dir input.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV prescaler producing a one-cycle step strobe.
module tick_prescaler #(
  parameter int DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 while enabled, wrap to 0, hold while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Strobe is combinational so it lines up with the terminal count; forced
  // low during reset because DIV=1 makes the cleared count terminal.
  assign tick = en && !rst && (cnt == LAST);

endmodule

// File: rtl/ring_counter_gen.sv
// Prescaled ring / Johnson counter with direction control, parallel load and
// a wrap pulse marking each return to the running pattern's seed.
module ring_counter_gen
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RING_SEED    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] JOHNSON_SEED = '0;

  function automatic logic [WIDTH-1:0] seed_of(input mode_e m);
    return (m == MODE_RING) ? RING_SEED : JOHNSON_SEED;
  endfunction

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  mode_e            mode_in;
  dir_e             dir_in;
  mode_e            mode_q;
  logic [WIDTH-1:0] step_count;

  assign mode_in = mode_e'(mode);
  assign dir_in  = dir_e'(dir);

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Next pattern for a normal step in the latched mode and current direction.
  always_comb begin
    step_count = count;
    if (mode_q == MODE_RING) begin
      if (dir_in == DIR_RIGHT) step_count = {count[0], count[WIDTH-1:1]};
      else                     step_count = {count[WIDTH-2:0], count[WIDTH-1]};
    end else begin
      if (dir_in == DIR_RIGHT) step_count = {~count[0], count[WIDTH-1:1]};
      else                     step_count = {count[WIDTH-2:0], ~count[WIDTH-1]};
    end
  end

  // Pattern register: load beats tick; a mode change or corrupt ring pattern
  // reseeds instead of stepping, and only a normal step may raise wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= RING_SEED;
      mode_q <= MODE_RING;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count  <= load_val;
        mode_q <= mode_in;
      end else if (tick) begin
        if (mode_in != mode_q) begin
          count  <= seed_of(mode_in);
          mode_q <= mode_in;
        end else if ((mode_q == MODE_RING) && !is_onehot(count)) begin
          count <= RING_SEED;
        end else begin
          count <= step_count;
          wrap  <= (step_count == seed_of(mode_q));
        end
      end
    end
  end

endmodule

// File: doc/ring_counter_gen.md
RING_COUNTER_GEN -- requirements
Module: ring_counter_gen

Interface
REQ-001 Parameter WIDTH, default 8, count register width; SHALL be >= 2.
REQ-002 Parameter DIV, default 1000000, clk cycles per step tick; SHALL be >= 1.
REQ-003 Port clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port en  input  1  prescaler/step enable.
REQ-006 Port mode  input  1  pattern select: 0 = ring (one-hot rotate), 1 = Johnson (twisted ring).
REQ-007 Port dir  input  1  shift direction: 0 = left (toward MSB), 1 = right.
REQ-008 Port load  input  1  synchronous parallel load strobe.
REQ-009 Port load_val  input  WIDTH  value written on load.
REQ-010 Port count  output  WIDTH  registered counter pattern.
REQ-011 Port tick  output  1  step strobe: high for one clk when the prescaler is at DIV-1 and en=1.
REQ-012 Port wrap  output  1  registered one-cycle pulse when the pattern returns to its mode seed.

Function
REQ-013 Prescaler counts 0..DIV-1 while en=1, returns to 0 after DIV-1, and holds its value while en=0; DIV=1 SHALL give tick=1 on every cycle with en=1.
REQ-014 Seeds: ring seed = 1 followed by WIDTH-1 zeros (MSB set); Johnson seed = all zeros.
REQ-015 Internal latched mode (mode_q) records the pattern currently running.
REQ-016 On a tick with mode != mode_q: count <= seed of mode, mode_q <= mode, wrap stays 0.
REQ-017 On a tick in ring mode with count not one-hot (zero or multiple bits set): count <= ring seed, wrap stays 0.
REQ-018 Ring step: left = rotate left (MSB into bit 0); right = rotate right (bit 0 into MSB).
REQ-019 Johnson step: left = shift left, inverted MSB into bit 0; right = shift right, inverted bit 0 into MSB.
REQ-020 Ring period SHALL be WIDTH ticks; Johnson period SHALL be 2*WIDTH ticks, for either direction.
REQ-021 wrap SHALL be 1 in the cycle following a normal step (REQ-018/019) whose result equals the current mode seed; 0 otherwise.
REQ-022 dir may change at any time; it takes effect on the next tick without reseeding.
REQ-023 load=1 SHALL take priority over a coincident tick: count <= load_val, mode_q <= mode, wrap <= 0; the prescaler is unaffected.
REQ-024 A non-one-hot load_val in ring mode SHALL be corrected per REQ-017 on the next tick.
REQ-025 No tick and no load: count, mode_q hold; wrap <= 0.

Reset
REQ-026 rst=1 SHALL immediately, independent of clk: count = ring seed, mode_q = ring, prescaler = 0, wrap = 0; tick = 0 while rst is high.
REQ-027 Operation SHALL restart from a full DIV-cycle prescaler interval on the first clk edge after rst deasserts.

Structure
REQ-028 Shared package ring_counter_pkg SHALL hold mode encodings (MODE_RING, MODE_JOHNSON) and direction encodings (DIR_LEFT, DIR_RIGHT).
REQ-029 Prescaler SHALL be sub-module tick_prescaler (parameter DIV, ports clk, rst, en, tick), counter width clog2(DIV), minimum 1 bit.
REQ-030 No derived or gated clocks; tick SHALL be used only as a clock enable.

Verification (WIDTH=8, DIV=4)
REQ-031 Reset, en=1, mode=0, dir=0 -> count=0x80; tick every 4th clk; count 0x01,0x02,...,0x80; wrap pulse after the 8th tick.
REQ-032 mode=1 from reset -> 1st tick reseeds to 0x00 with no wrap; then 0x01,0x03,0x07,...,0xFF,0xFE,...,0x80,0x00; wrap after the 16th step.
REQ-033 Ring, dir=1 from 0x80 -> 0x40,0x20,...,0x01,0x80; wrap on return to 0x80; toggling dir mid-sequence reverses without a reseed.
REQ-034 load=1 with load_val=0x24 coincident with a tick -> count=0x24, no step; next tick -> 0x80 with wrap=0.
REQ-035 rst pulsed between clk edges mid-run -> count=0x80 and wrap=0 before the next edge; en=0 afterwards -> count and prescaler frozen, tick=0.
